alu_issue_stage: RTL

- Upstream neighbour of the 32-bit ALU. Accepts operation/operand tokens from the decode side over a valid/ready handshake.
- Filters out opcodes the ALU does not implement and buffers legal tokens in a small FIFO.
- Presents the FIFO head as a registered, stable {operation, operandA, operandB} to the ALU.
- Guarantees the ALU never sees an undefined opcode, which would otherwise leave its result latched.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/alu_issue_fifo.sv | 58 +++++
 rtl/alu_issue_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode map, token layout and legality check shared by the ALU issue stage.
`default_nettype none

package alu_pkg;

  localparam int OP_W   = 6;
  localparam int DATA_W = 32;

  localparam logic [OP_W-1:0] OP_ADD   = 6'h00;
  localparam logic [OP_W-1:0] OP_SUB   = 6'h02;
  localparam logic [OP_W-1:0] OP_AND   = 6'h03;
  localparam logic [OP_W-1:0] OP_OR    = 6'h04;
  localparam logic [OP_W-1:0] OP_XOR   = 6'h05;
  localparam logic [OP_W-1:0] OP_NOR   = 6'h06;
  localparam logic [OP_W-1:0] OP_PASSB = 6'h09;
  localparam logic [OP_W-1:0] OP_SLL   = 6'h0D;
  localparam logic [OP_W-1:0] OP_SRL   = 6'h0E;
  localparam logic [OP_W-1:0] OP_SRA   = 6'h0F;
  localparam logic [OP_W-1:0] OP_SLT   = 6'h10;
  localparam logic [OP_W-1:0] OP_PASSA = 6'h11;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'h12;
  localparam logic [OP_W-1:0] OP_MUL   = 6'h13;
  localparam logic [OP_W-1:0] OP_MULH  = 6'h14;
  localparam logic [OP_W-1:0] OP_EQ    = 6'h15;
  localparam logic [OP_W-1:0] OP_NE    = 6'h16;
  localparam logic [OP_W-1:0] OP_LT    = 6'h17;
  localparam logic [OP_W-1:0] OP_GE    = 6'h18;
  localparam logic [OP_W-1:0] OP_LTU   = 6'h19;
  localparam logic [OP_W-1:0] OP_GEU   = 6'h1A;
  localparam logic [OP_W-1:0] OP_NOT   = 6'h1B;
  localparam logic [OP_W-1:0] OP_NEG   = 6'h1C;
  localparam logic [OP_W-1:0] OP_MIN   = 6'h1D;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } issue_tok_t;

  localparam int TOK_W = $bits(issue_tok_t);

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_PASSB,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_PASSA, OP_SLTU, OP_MUL,
      OP_MULH, OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU,
      OP_NOT, OP_NEG, OP_MIN: is_legal_op = 1'b1;
      default:                is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: DEPTH x W synchronous FIFO; head reads as zero when empty.
`default_nettype none

module alu_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 70
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == OCC_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: drops opcodes the ALU lacks, buffers legal tokens, counts drops.
// Optional macro ALU_ISSUE_PASSB_FIX_EN rewrites PASSB into PASSA with operand B moved to A.
`default_nettype none

module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_operation,
  input  logic [31:0]      in_operandA,
  input  logic [31:0]      in_operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       operation,
  output logic [31:0]      operandA,
  output logic [31:0]      operandB,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  issue_tok_t       w_wr_tok;
  issue_tok_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_legal;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_count;

  assign in_ready = ~w_full;
  assign out_valid = ~w_empty;
  assign w_accept = in_valid & in_ready;
  assign w_legal  = is_legal_op(in_operation);

  always_comb begin
    w_wr_tok.op = in_operation;
    w_wr_tok.a  = in_operandA;
    w_wr_tok.b  = in_operandB;
`ifdef ALU_ISSUE_PASSB_FIX_EN
    if (in_operation == OP_PASSB) begin
      w_wr_tok.op = OP_PASSA;
      w_wr_tok.a  = in_operandB;
    end
`endif
  end

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     (TOK_W)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_accept & w_legal),
    .i_wdata (w_wr_tok),
    .i_pop   (out_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign operation = w_head.op;
  assign operandA  = w_head.a;
  assign operandB  = w_head.b;

  // Dropped tokens still complete the handshake; only the pulse and counter record them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_illegal       <= 1'b0;
      r_illegal_count <= '0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept && !w_legal && (r_illegal_count != {CNT_W{1'b1}}))
        r_illegal_count <= r_illegal_count + CNT_W'(1);
    end
  end

  assign illegal       = r_illegal;
  assign illegal_count = r_illegal_count;

endmodule

`default_nettype wire
